// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, presents it to a combinational instruction
// memory and registers the returned word into a valid/ready slot for decode.
module fetch_stage #(
  parameter int unsigned          dataWidth = 64,
  parameter int unsigned          instWidth = 32,
  parameter logic [dataWidth-1:0] resetPc   = '0,
  parameter int unsigned          pcStep    = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  output logic [dataWidth-1:0] currentPc,
  input  logic [dataWidth-1:0] instruction,
  input  logic                 redirectValid,
  input  logic [dataWidth-1:0] redirectPc,
  input  logic                 haltReq,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [instWidth-1:0] outInstruction,
  output logic [dataWidth-1:0] outPc,
  output logic [31:0]          fetchCount,
  output logic                 halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e               state_q;
  logic [dataWidth-1:0] pc_q;
  logic [dataWidth-1:0] pc_d;
  logic [dataWidth-1:0] out_pc_q;
  logic [instWidth-1:0] out_inst_q;
  logic                 out_valid_q;
  logic [31:0]          fetch_count_q;
  logic                 halted_q;
  logic                 fire;

  assign pc_d = pc_q + dataWidth'(pcStep);

  // A fetch needs RUN, no competing control request, and a free or draining slot.
  assign fire = (state_q == RUN) && !redirectValid && !haltReq
                && (!out_valid_q || outReady);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= BOOT;
      pc_q          <= resetPc;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_valid_q   <= 1'b0;
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
    end else if (redirectValid) begin
      // Redirect flushes the slot even if decode is accepting it this cycle.
      state_q     <= RUN;
      pc_q        <= {redirectPc[dataWidth-1:2], 2'b00};
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      if (fire) begin
        out_inst_q    <= instruction[instWidth-1:0];
        out_pc_q      <= pc_q;
        out_valid_q   <= 1'b1;
        pc_q          <= pc_d;
        fetch_count_q <= fetch_count_q + 32'd1;
      end else if (out_valid_q && outReady) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (haltReq) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: state_q <= HALT;
        default: begin
          state_q  <= BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign currentPc      = pc_q;
  assign outValid       = out_valid_q;
  assign outInstruction = out_inst_q;
  assign outPc          = out_pc_q;
  assign fetchCount     = fetch_count_q;
  assign halted         = halted_q;

  // Bits the stage deliberately ignores: upper memory data and redirect alignment.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirectPc[1:0];

  generate
    if (dataWidth > instWidth) begin : g_unused_inst
      logic unused_inst_bits;
      assign unused_inst_bits = ^instruction[dataWidth-1:instWidth];
    end
  endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; each vector is one clock edge with
// outputs checked on the following falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetN;
  logic [63:0] currentPc;
  logic [63:0] instruction;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic        haltReq;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstruction;
  logic [63:0] outPc;
  logic [31:0] fetchCount;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign instruction = {32'h0, currentPc[31:0] ^ 32'hC0DE0000};

  fetch_stage #(
    .dataWidth(64),
    .instWidth(32),
    .resetPc  (64'h0),
    .pcStep   (4)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .currentPc     (currentPc),
    .instruction   (instruction),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .haltReq       (haltReq),
    .outValid      (outValid),
    .outReady      (outReady),
    .outInstruction(outInstruction),
    .outPc         (outPc),
    .fetchCount    (fetchCount),
    .halted        (halted)
  );

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        hreq;
    logic        rdy;
    logic        ov;
    logic [63:0] opc;
    logic [31:0] oinst;
    logic [31:0] fc;
    logic        hl;
    logic [63:0] cpc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [63:0] opc,
                           input logic [31:0] oinst, input logic [31:0] fc,
                           input logic hl, input logic [63:0] cpc);
    check({tag, ".outValid"}, 64'(outValid), 64'(ov));
    check({tag, ".outPc"}, outPc, opc);
    check({tag, ".outInstruction"}, 64'(outInstruction), 64'(oinst));
    check({tag, ".fetchCount"}, 64'(fetchCount), 64'(fc));
    check({tag, ".halted"}, 64'(halted), 64'(hl));
    check({tag, ".currentPc"}, currentPc, cpc);
  endtask

  initial begin
    //                rv   rpc                    hreq rdy  ov   opc                    oinst          fc     hl   cpc
    // Boot, then stream with outReady high.
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 64'h0,                 32'h0,         32'd0,  1'b0, 64'h0});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h0,                 32'hC0DE0000,  32'd1,  1'b0, 64'h4});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h4,                 32'hC0DE0004,  32'd2,  1'b0, 64'h8});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h8,                 32'hC0DE0008,  32'd3,  1'b0, 64'hC});
    // Backpressure for three cycles on the 0x8 slot, then release.
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'h8,                 32'hC0DE0008,  32'd3,  1'b0, 64'hC});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'h8,                 32'hC0DE0008,  32'd3,  1'b0, 64'hC});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'h8,                 32'hC0DE0008,  32'd3,  1'b0, 64'hC});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'hC,                 32'hC0DE000C,  32'd4,  1'b0, 64'h10});
    // Stall, then redirect to 0x103 while stalled.
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'hC,                 32'hC0DE000C,  32'd4,  1'b0, 64'h10});
    vecs.push_back('{1'b1, 64'h103,               1'b0, 1'b0, 1'b0, 64'hC,                 32'hC0DE000C,  32'd4,  1'b0, 64'h100});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h100,               32'hC0DE0100,  32'd5,  1'b0, 64'h104});
    // Redirect with outReady high still flushes; then halt with a held slot.
    vecs.push_back('{1'b1, 64'h20,                1'b0, 1'b1, 1'b0, 64'h100,               32'hC0DE0100,  32'd5,  1'b0, 64'h20});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'h20,                32'hC0DE0020,  32'd6,  1'b0, 64'h24});
    vecs.push_back('{1'b0, 64'h0,                 1'b1, 1'b0, 1'b1, 64'h20,                32'hC0DE0020,  32'd6,  1'b1, 64'h24});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 64'h20,                32'hC0DE0020,  32'd6,  1'b1, 64'h24});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 64'h20,                32'hC0DE0020,  32'd6,  1'b1, 64'h24});
    vecs.push_back('{1'b0, 64'h0,                 1'b1, 1'b1, 1'b0, 64'h20,                32'hC0DE0020,  32'd6,  1'b1, 64'h24});
    // Redirect out of HALT.
    vecs.push_back('{1'b1, 64'h40,                1'b0, 1'b1, 1'b0, 64'h20,                32'hC0DE0020,  32'd6,  1'b0, 64'h40});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h40,                32'hC0DE0040,  32'd7,  1'b0, 64'h44});
    // Redirect and halt together: redirect wins, still in RUN.
    vecs.push_back('{1'b1, 64'h80,                1'b1, 1'b1, 1'b0, 64'h40,                32'hC0DE0040,  32'd7,  1'b0, 64'h80});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h80,                32'hC0DE0080,  32'd8,  1'b0, 64'h84});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h84,                32'hC0DE0084,  32'd9,  1'b0, 64'h88});
    // PC wrap at the top of the address space.
    vecs.push_back('{1'b1, 64'hFFFFFFFFFFFFFFFC,  1'b0, 1'b1, 1'b0, 64'h84,                32'hC0DE0084,  32'd9,  1'b0, 64'hFFFFFFFFFFFFFFFC});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC,  32'h3F21FFFC,  32'd10, 1'b0, 64'h0});
    vecs.push_back('{1'b0, 64'h0,                 1'b0, 1'b1, 1'b1, 64'h0,                 32'hC0DE0000,  32'd11, 1'b0, 64'h4});

    resetN        = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    haltReq       = 1'b0;
    outReady      = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 64'h0, 32'h0, 32'd0, 1'b0, 64'h0);
    $display("reset: outValid=%0b currentPc=%h fetchCount=%0d", outValid, currentPc, fetchCount);
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      redirectValid = vecs[i].rv;
      redirectPc    = vecs[i].rpc;
      haltReq       = vecs[i].hreq;
      outReady      = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].opc, vecs[i].oinst,
                vecs[i].fc, vecs[i].hl, vecs[i].cpc);
      $display("vec %0d: rv=%0b hreq=%0b rdy=%0b -> outValid=%0b outPc=%h inst=%h count=%0d halted=%0b pc=%h",
               i, vecs[i].rv, vecs[i].hreq, vecs[i].rdy, outValid, outPc, outInstruction,
               fetchCount, halted, currentPc);
    end

    // Asynchronous reset in mid-cycle while the slot is full.
    redirectValid = 1'b0;
    haltReq       = 1'b0;
    outReady      = 1'b1;
    #2 resetN = 1'b0;
    #1;
    check_all("midreset", 1'b0, 64'h0, 32'h0, 32'd0, 1'b0, 64'h0);
    $display("midreset: outValid=%0b outPc=%h count=%0d pc=%h", outValid, outPc, fetchCount, currentPc);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all("postreset_boot", 1'b0, 64'h0, 32'h0, 32'd0, 1'b0, 64'h0);
    $display("postreset boot: outValid=%0b pc=%h", outValid, currentPc);
    @(posedge clk);
    @(negedge clk);
    check_all("postreset_fetch", 1'b1, 64'h0, 32'hC0DE0000, 32'd1, 1'b0, 64'h4);
    $display("postreset fetch: outValid=%0b outPc=%h inst=%h count=%0d", outValid, outPc,
             outInstruction, fetchCount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter and drives `currentPc` into the combinational instruction memory. It captures the returned word into a registered fetch/decode output slot that the decoder reads through a valid/ready handshake. It supports decoder backpressure, branch/jump redirect with flush of the held instruction, and a halt request. It sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- `dataWidth`, 64, width of PC and of the instruction-memory data bus
- `instWidth`, 32, instruction bits taken from `instruction[instWidth-1:0]`
- `resetPc`, 0, PC value loaded on reset
- `pcStep`, 4, PC increment per fetched instruction
- `clk`  in  1  single clock, all state on rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `currentPc`  out  dataWidth  address to instruction memory; combinationally equal to the internal PC register
- `instruction`  in  dataWidth  memory read data for `currentPc`, valid in the same cycle
- `redirectValid`  in  1  load a new PC and flush the output slot
- `redirectPc`  in  dataWidth  redirect target; low 2 bits forced to 0 on load
- `haltReq`  in  1  stop fetching
- `outValid`  out  1  output slot holds an instruction
- `outReady`  in  1  decoder accepts the slot this cycle
- `outInstruction`  out  instWidth  captured instruction
- `outPc`  out  dataWidth  PC the instruction was fetched from
- `fetchCount`  out  32  number of fetches performed; wraps at 2^32
- `halted`  out  1  high while in HALT

## Operation
- States are BOOT, RUN and HALT.
- BOOT lasts one cycle after reset release with no fetch, then goes to RUN.
- Fire condition is `state==RUN && !redirectValid && !haltReq && (!outValid || outReady)`.
- On fire:
  - `outInstruction <= instruction[instWidth-1:0]`, `outPc <= pc`, `outValid <= 1`.
  - `pc <= pc + pcStep`, modulo 2^dataWidth.
  - `fetchCount <= fetchCount + 1`.
- Accept without fire (`outValid && outReady`, no fire): `outValid <= 0`.
- Stall (`outValid && !outReady`): slot, `pc` and `fetchCount` hold. `outInstruction` and `outPc` stay stable.
- Redirect has priority over everything in any state:
  - `pc <= {redirectPc[dataWidth-1:2], 2'b00}`, `outValid <= 0` (the slot is flushed even if `outReady` is high), no fetch that cycle.
  - Next state is RUN, including from BOOT or HALT.
- `haltReq` without redirect in RUN:
  - Next state is HALT, no fetch that cycle.
  - The slot still drains normally through the handshake.
- HALT: no fetches, `pc` holds, `halted=1`, `haltReq` is ignored. Only redirect or reset leaves HALT.
- `outValid` never falls without an accept, except on redirect or reset.

## Timing
- Reset values (asynchronous, immediate on `resetN` low):
  - `pc=resetPc`, so `currentPc=resetPc`
  - `outValid=0`, `outInstruction=0`, `outPc=0`, `fetchCount=0`, `halted=0`
  - state BOOT
- After `resetN` rises: edge 1 moves BOOT to RUN; edge 2 performs the first fetch and `outValid` is high after it.
- Latency: memory word is registered at the fire edge and appears on outputs one cycle after `currentPc` is presented.
- Throughput: 1 instruction per cycle with `outReady` held high.
- Redirect at edge N: `currentPc` equals the target after N and the target's instruction is valid after N+1. The redirect bubble is 1 cycle.
- `halted` is a registered state decode and rises one edge after `haltReq` is sampled.
- Reset asserted mid-stream discards the slot and returns to BOOT regardless of handshake.

## Test plan
- Bench memory returns `instruction = {32'h0, currentPc[31:0] ^ 32'hC0DE0000}`.
- Reset and stream, `outReady=1`: `outPc` = 0,4,8,12 on consecutive cycles starting 2 edges after release; `outInstruction`=C0DE0000, C0DE0004, …; `fetchCount`=4 after 4 fetches.
- Backpressure: drop `outReady` for 3 cycles while `outValid` with `outPc=8` → slot holds 8/C0DE0008, `currentPc` holds 12. Raise `outReady` → next `outPc`=12, no duplicate or skipped PC.
- Redirect while stalled, `redirectPc=0x103`: slot flushed (`outValid=0`) the next cycle, `currentPc=0x100`, next valid `outPc=0x100` one cycle later. `fetchCount` does not count the flushed cycle.
- Halt then resume: `haltReq` for 1 cycle at `pc=0x20` → `halted=1`, no further fetches, slot drains. Redirect to 0x40 → `halted=0`, next `outPc=0x40`.
- Simultaneous redirect and `haltReq` in RUN: redirect wins, state stays RUN.
- Same-cycle fire and accept with `outReady=1`: no bubble.
- Wrap: redirect to 0xFFFFFFFFFFFFFFFC, fetch twice → `outPc` = …FFFC then 0x0.
- Reset mid-operation with `outValid=1`: all outputs return to reset values immediately. The first fetch after release has `outPc=resetPc`.
